lfsr_histogram_unit: RTL and testbench

Parametrised successor to the fixed 7-bit LFSR plus histogram pair. A configurable Fibonacci LFSR feeds a bank of saturating bin counters for a programmed number of samples. The finished histogram is then streamed out over a valid/ready port, and an explicit clear sequence zeroes it. The block sits as a self-test and statistics source beside the lab top level and replaces the free-running, enable-gated histogram.

---
 rtl/lfsr_histogram_unit.sv | 189 ++++++++++++++++++
 tb/tb_lfsr_histogram_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_histogram_unit.sv
// Fibonacci LFSR feeding a bank of saturating bin counters; the finished
// histogram is streamed out over valid/ready and can be zeroed by a clear pass.
module lfsr_histogram_unit #(
    parameter int unsigned LFSR_W   = 7,
    parameter logic [31:0] TAPS     = 32'h65,
    parameter logic [31:0] SEED     = 32'h1,
    parameter int unsigned BIN_BITS = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic                clear,
    input  logic [15:0]         num_samples,
    output logic                busy,
    output logic                done,
    output logic [LFSR_W-1:0]   lfsr_out,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [BIN_BITS-1:0] rd_bin,
    output logic [CNT_W-1:0]    rd_count,
    output logic                rd_last
);

    localparam int unsigned         NBINS    = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NBINS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP, S_CLEAR} state_e;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    bins_q [NBINS];
    logic [CNT_W-1:0]    bins_d [NBINS];
    logic [15:0]         nsamp_q, nsamp_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [BIN_BITS-1:0] idx_q, idx_d;
    logic [BIN_BITS-1:0] rd_bin_q, rd_bin_d;
    logic [CNT_W-1:0]    rd_count_q, rd_count_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic                fb;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [BIN_BITS-1:0] cur_bin;
    logic [BIN_BITS-1:0] nxt_bin;
    logic [15:0]         cnt_inc;
    logic                handshake;

    always_comb begin
        fb        = ^(lfsr_q & TAPS[LFSR_W-1:0]);
        lfsr_step = (lfsr_q == '0) ? SEED[LFSR_W-1:0] : {lfsr_q[LFSR_W-2:0], fb};
        cur_bin   = lfsr_q[LFSR_W-1 -: BIN_BITS];
        nxt_bin   = rd_bin_q + 1'b1;
        cnt_inc   = cnt_q + 16'd1;
        handshake = rd_valid_q && rd_ready;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED[LFSR_W-1:0];
            for (int unsigned i = 0; i < NBINS; i++) begin
                bins_q[i] <= '0;
            end
            nsamp_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            rd_bin_q   <= '0;
            rd_count_q <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            bins_q     <= bins_d;
            nsamp_q    <= nsamp_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rd_bin_q   <= rd_bin_d;
            rd_count_q <= rd_count_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLEAR;
                end else if (start) begin
                    state_d = (num_samples == 16'd0) ? S_DUMP : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_inc == nsamp_q) begin
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (handshake && rd_last_q) begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (idx_q == LAST_BIN) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lfsr_d     = lfsr_q;
        bins_d     = bins_q;
        nsamp_d    = nsamp_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rd_bin_d   = rd_bin_q;
        rd_count_d = rd_count_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        done_d     = 1'b0;
        busy_d     = (state_d != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    idx_d = '0;
                end else if (start) begin
                    nsamp_d = num_samples;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (bins_q[cur_bin] != '1) begin
                    bins_d[cur_bin] = bins_q[cur_bin] + 1'b1;
                end
                lfsr_d = lfsr_step;
                cnt_d  = cnt_inc;
            end
            S_DUMP: begin
                if (handshake) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        rd_bin_d   = '0;
                        rd_count_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        rd_bin_d   = nxt_bin;
                        rd_count_d = bins_q[nxt_bin];
                        rd_last_d  = (nxt_bin == LAST_BIN);
                    end
                end
            end
            S_CLEAR: begin
                bins_d[idx_q] = '0;
                idx_d         = idx_q + 1'b1;
            end
            default: ;
        endcase

        // First word is loaded from bins_d so the final RUN increment is included.
        if (state_q != S_DUMP && state_d == S_DUMP) begin
            rd_valid_d = 1'b1;
            rd_bin_d   = '0;
            rd_count_d = bins_d[0];
            rd_last_d  = (LAST_BIN == '0);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign lfsr_out = lfsr_q;
    assign rd_valid = rd_valid_q;
    assign rd_bin   = rd_bin_q;
    assign rd_count = rd_count_q;
    assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_lfsr_histogram_unit.sv
// Scoreboard bench for lfsr_histogram_unit: a behavioural histogram model
// queues the expected readout words, a monitor checks every presented word.
module tb_lfsr_histogram_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] num_samples = '0;
    logic        rd_ready = 1'b0;
    logic        busy, done, rd_valid, rd_last;
    logic [6:0]  lfsr_out;
    logic [2:0]  rd_bin;
    logic [7:0]  rd_count;

    lfsr_histogram_unit dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .clear       (clear),
        .num_samples (num_samples),
        .busy        (busy),
        .done        (done),
        .lfsr_out    (lfsr_out),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_bin      (rd_bin),
        .rd_count    (rd_count),
        .rd_last     (rd_last)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int bin;
        int count;
        int last;
    } word_t;

    word_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    pops = 0;
    int    m_lfsr = 1;
    int    m_hist[8];
    bit    pat_mode = 0;
    int    pat_idx = 0;
    bit    pat[5] = '{0, 1, 0, 0, 1};

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: 7-bit state, feedback = parity of taps {6,5,2,0}, zero reloads seed.
    function automatic int m_step(input int s);
        if (s == 0) return 1;
        return ((s << 1) & 127) | ($countones(s & 'h65) & 1);
    endfunction

    task automatic model_run(input int ns);
        int b;
        for (int i = 0; i < ns; i++) begin
            b = m_lfsr / 16;
            if (m_hist[b] < 255) m_hist[b]++;
            m_lfsr = m_step(m_lfsr);
        end
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back('{j, m_hist[j], (j == 7) ? 1 : 0});
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < 8; j++) m_hist[j] = 0;
    endtask

    always @(posedge CLK) begin
        #2;
        if (pat_mode) begin
            rd_ready = pat[pat_idx % 5];
            pat_idx++;
        end else begin
            rd_ready = 1'($urandom_range(0, 1));
        end
    end

    word_t w;
    always @(negedge CLK) begin
        if (RST_N && rd_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got bin %0d count %0d expected no word", rd_bin, rd_count);
            end else begin
                w = exp_q[0];
                check("rd_bin", rd_bin, w.bin);
                check("rd_count", rd_count, w.count);
                check("rd_last", rd_last, w.last);
                if (rd_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic run(input int ns);
        int k;
        int p0;
        @(negedge CLK);
        start = 1'b1;
        num_samples = 16'(ns);
        model_run(ns);
        p0 = pops;
        @(posedge CLK);
        #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        k = 0;
        if (ns > 2) begin
            clear = 1'b1;
            start = 1'b1;
            @(posedge CLK);
            #1 clear = 1'b0;
            start = 1'b0;
            k = 1;
        end
        while (!rd_valid && k < ns + 5) begin
            @(posedge CLK);
            #1 k++;
        end
        check("dump_latency", k, ns);
        k = 0;
        while (!done && k < 300) begin
            @(posedge CLK);
            #1 k++;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        check("handshakes", pops - p0, 8);
        check("lfsr_after_run", lfsr_out, m_lfsr);
        check("queue_drained", exp_q.size(), 0);
        @(posedge CLK);
        #1 check("done_single_pulse", done, 0);
    endtask

    task automatic do_clear(input bit with_start);
        int n;
        bit seen;
        @(negedge CLK);
        clear = 1'b1;
        start = with_start;
        num_samples = 16'd5;
        @(posedge CLK);
        #1 clear = 1'b0;
        start = 1'b0;
        model_clear();
        n = 0;
        seen = 0;
        while (busy && n < 20) begin
            if (rd_valid) seen = 1;
            @(posedge CLK);
            #1 n++;
        end
        check("clear_busy_cycles", n, 8);
        check("clear_no_valid", seen, 0);
        check("clear_lfsr_kept", lfsr_out, m_lfsr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lfsr"}, lfsr_out, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_rd_bin"}, rd_bin, 0);
        check({tag, "_rd_count"}, rd_count, 0);
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge CLK);
        #1 check_reset_values("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        run(1);

        do_clear(1'b0);
        pat_mode = 1;
        run(127);
        pat_mode = 0;

        run(0);
        do_clear(1'b0);
        run(0);

        do_clear(1'b1);
        run(0);

        for (int r = 0; r < 3; r++) begin
            run(int'($urandom_range(1, 300)));
        end

        run(2100);

        @(negedge CLK);
        start = 1'b1;
        num_samples = 16'd100;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (50) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1 check_reset_values("reset_mid_run");
        m_lfsr = 1;
        model_clear();
        exp_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        run(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
